// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// returns {remainder, quotient} with a registered ready flag held until start drops.
//
// state    | meaning
// S_FREE   | idle, waiting for start without annul
// S_BYZERO | divisor was zero, result of 0 presented on next edge
// S_ON     | iterating, cnt counts steps 0..32
// S_END    | result presented, held while start stays high
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [64:0] work, work_nxt;
  logic [31:0] dvs, dvs_nxt;
  logic        neg_q, neg_q_nxt;
  logic        neg_r, neg_r_nxt;
  logic [63:0] result_nxt;
  logic        ready_nxt;

  logic [31:0] mag1, mag2;
  logic [32:0] diff;
  logic [31:0] quo, rem;

  // 0x80000000 negates to itself and is then used as an unsigned magnitude
  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  assign diff = {1'b0, work[63:32]} - {1'b0, dvs};
  assign quo  = work[31:0];
  assign rem  = work[64:33];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= 6'd0;
      work     <= 65'd0;
      dvs      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      work     <= work_nxt;
      dvs      <= dvs_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    work_nxt   = work;
    dvs_nxt    = dvs;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    result_nxt = result_o;
    ready_nxt  = ready_o;

    case (state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_nxt = S_BYZERO;
          end else begin
            state_nxt = S_ON;
            cnt_nxt   = 6'd0;
            work_nxt  = {32'd0, mag1, 1'b0};
            dvs_nxt   = mag2;
            neg_q_nxt = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_r_nxt = signed_div_i && opdata1_i[31];
          end
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_nxt  = S_FREE;
          cnt_nxt    = 6'd0;
          ready_nxt  = 1'b0;
          result_nxt = 64'd0;
        end else begin
          state_nxt  = S_END;
          result_nxt = 64'd0;
          ready_nxt  = 1'b1;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_nxt  = S_FREE;
          cnt_nxt    = 6'd0;
          ready_nxt  = 1'b0;
          result_nxt = 64'd0;
        end else if (cnt < 6'd32) begin
          if (diff[32]) work_nxt = {work[63:0], 1'b0};
          else          work_nxt = {diff[31:0], work[31:0], 1'b1};
          cnt_nxt = cnt + 6'd1;
        end else begin
          result_nxt = {(neg_r ? (~rem + 32'd1) : rem), (neg_q ? (~quo + 32'd1) : quo)};
          ready_nxt  = 1'b1;
          state_nxt  = S_END;
        end
      end

      S_END: begin
        if (!start_i || annul_i) begin
          state_nxt  = S_FREE;
          ready_nxt  = 1'b0;
          result_nxt = 64'd0;
        end
      end

      default: state_nxt = S_FREE;
    endcase
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus random operands checked
// against an arithmetic reference model.
module tb_div;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (opdata1),
    .opdata2_i   (opdata2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = (s && a[31]) ? 32'd0 - a : a;
    mb = (s && b[31]) ? 32'd0 - b : b;
    q = ma / mb;
    r = ma % mb;
    if (s && (a[31] != b[31])) q = 32'd0 - q;
    if (s && a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Full request: accept, busy window, result, hold, release.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag,
                        input bit scramble, input bit drop_mid);
    int lat;
    lat = (b == 32'd0) ? 1 : 33;
    signed_div = s; opdata1 = a; opdata2 = b; start = 1'b1; annul = 1'b0;
    tick();
    chk({tag, "_busy0"}, {63'd0, ready}, 64'd0);
    for (int e = 1; e < lat; e++) begin
      if (scramble) begin opdata1 = $urandom; opdata2 = $urandom; end
      if (drop_mid && e == 5) start = 1'b0;
      tick();
      chk({tag, "_busy"}, {63'd0, ready}, 64'd0);
    end
    tick();
    chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    chk({tag, "_result"}, result, exp);
    if (!drop_mid) begin
      tick();
      chk({tag, "_hold"}, result, exp);
      chk({tag, "_hold_rdy"}, {63'd0, ready}, 64'd1);
      start = 1'b0;
      tick();
    end else begin
      tick();
    end
    chk({tag, "_rel_rdy"}, {63'd0, ready}, 64'd0);
    chk({tag, "_rel_res"}, result, 64'd0);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;

    rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
    #12;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1'b0;
    tick();

    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_100_7", 0, 0);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2", 0, 0);
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7_m2", 0, 0);

    // Zero divisor with extended hold
    signed_div = 1'b0; opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1;
    tick();
    chk("byzero_e0", {63'd0, ready}, 64'd0);
    tick();
    chk("byzero_ready", {63'd0, ready}, 64'd1);
    chk("byzero_result", result, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("byzero_hold", {63'd0, ready}, 64'd1);
      chk("byzero_hold_res", result, 64'd0);
    end
    start = 1'b0;
    tick();
    chk("byzero_drop", {63'd0, ready}, 64'd0);

    // Annul at E10, then a new request two edges later
    signed_div = 1'b0; opdata1 = 32'hFFFFFFFF; opdata2 = 32'd3; start = 1'b1;
    tick();
    for (int e = 1; e < 10; e++) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0; start = 1'b0;
    chk("annul_ready", {63'd0, ready}, 64'd0);
    for (int e = 0; e < 30; e++) begin
      if (e == 0) begin
        tick();
        chk("annul_idle", {63'd0, ready}, 64'd0);
      end
    end
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after_annul", 0, 0);
    // Confirm the annulled divide never completed late
    chk("annul_no_late", {63'd0, ready}, 64'd0);

    // start+annul together in FREE must not accept
    signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    do_div(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, "start_annul", 0, 0);

    // Asynchronous reset while a result is presented
    signed_div = 1'b0; opdata1 = 32'd20; opdata2 = 32'd0; start = 1'b1;
    tick(); tick();
    chk("pre_reset_ready", {63'd0, ready}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", {63'd0, ready}, 64'd0);
    chk("async_rst_result", result, 64'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Reset mid-division between E15 and E16
    signed_div = 1'b0; opdata1 = 32'd12345; opdata2 = 32'd17; start = 1'b1;
    tick();
    for (int e = 1; e <= 15; e++) tick();
    #2 rst = 1'b1;
    #1;
    chk("midop_rst_ready", {63'd0, ready}, 64'd0);
    chk("midop_rst_result", result, 64'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("midop_rst_idle", {63'd0, ready}, 64'd0);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "overflow", 0, 0);

    do_div(1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, "operand_hold", 1, 0);
    do_div(1'b0, 32'd77, 32'd8, model(1'b0, 32'd77, 32'd8), "start_drop", 0, 1);
    do_div(1'b1, 32'h80000000, 32'd1, model(1'b1, 32'h80000000, 32'd1), "min_by_1", 0, 0);
    do_div(1'b0, 32'hFFFFFFFF, 32'h80000001, model(1'b0, 32'hFFFFFFFF, 32'h80000001), "big_div", 0, 0);

    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom;
        3:       b = 32'd0 - $urandom_range(1, 100);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_div(s, a, b, model(s, a, b), "random", 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
